pulse_burst_gen: RTL

PULSE_BURST_GEN -- requirements
Module: pulse_burst_gen

---
 rtl/pulse_burst_gen_pkg.sv | 15 +
 rtl/pulse_phase_timer.sv | 29 ++
 rtl/pulse_burst_gen.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pulse_burst_gen_pkg.sv
// Shared types and defaults for the pulse burst generator.
// Holds the FSM state encoding and default widths.
package pulse_burst_gen_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int WID_W_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_DONE = 2'd3
  } pbg_state_t;

endpackage

// File: rtl/pulse_phase_timer.sv
// Loadable down-counter timing HIGH/LOW phases.
// expire pulses on the last cycle of a running phase.
module pulse_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         run,
  output logic         expire
);

  logic [W-1:0] cnt_q;

  // load wins over counting; counter parks at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (run && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = run && (cnt_q == '0);

endmodule

// File: rtl/pulse_burst_gen.sv
// Burst pulse generator: N pulses of programmable
// high/low width, with abort and done strobe.
module pulse_burst_gen
  import pulse_burst_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WID_W = WID_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_count,
  input  logic [WID_W-1:0] req_high,
  input  logic [WID_W-1:0] req_low,
  input  logic             abort,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulses_sent
);

  pbg_state_t       state_q, state_n;
  logic [WID_W-1:0] hi_q, hi_n;
  logic [WID_W-1:0] lo_q, lo_n;
  logic [CNT_W-1:0] rem_q, rem_n;
  logic [CNT_W-1:0] sent_q, sent_n;
  logic             pulse_q;

  logic             t_load;
  logic [WID_W-1:0] t_val;
  logic             t_run;
  logic             t_exp;

  // A width of 0 behaves as 1, so reload is max(w,1)-1.
  function automatic logic [WID_W-1:0] reload(
    input logic [WID_W-1:0] w
  );
    return (w == '0) ? '0 : w - 1'b1;
  endfunction

  pulse_phase_timer #(
    .W (WID_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .run      (t_run),
    .expire   (t_exp)
  );

  // next-state, capture and counter update logic
  always_comb begin
    state_n = state_q;
    hi_n    = hi_q;
    lo_n    = lo_q;
    rem_n   = rem_q;
    sent_n  = sent_q;
    t_load  = 1'b0;
    t_val   = '0;
    t_run   = (state_q == S_HIGH) ||
              (state_q == S_LOW);
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && !abort) begin
          hi_n   = req_high;
          lo_n   = req_low;
          rem_n  = req_count;
          sent_n = '0;
          t_load = 1'b1;
          t_val  = reload(req_high);
          state_n = (req_count == '0) ?
                    S_DONE : S_HIGH;
        end
      end
      S_HIGH: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (t_exp) begin
          sent_n = sent_q + 1'b1;
          rem_n  = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) begin
            state_n = S_DONE;
          end else begin
            state_n = S_LOW;
            t_load  = 1'b1;
            t_val   = reload(lo_q);
          end
        end
      end
      S_LOW: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (t_exp) begin
          state_n = S_HIGH;
          t_load  = 1'b1;
          t_val   = reload(hi_q);
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // state and registered pulse output
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      rem_q   <= '0;
      sent_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_n;
      hi_q    <= hi_n;
      lo_q    <= lo_n;
      rem_q   <= rem_n;
      sent_q  <= sent_n;
      pulse_q <= (state_n == S_HIGH);
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE) && !abort;
  assign pulse_out   = pulse_q;
  assign pulses_sent = sent_q;

endmodule
